// File: rtl/led_display.sv
// Four-digit multiplexed 7-segment driver for the selected 6502 bus/register value.
// The value is captured once per frame so that a refresh never mixes two values.
module led_display #(
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned BLANK    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  ledsel,
  input  logic [15:0] addr,
  input  logic [7:0]  data,
  input  logic [7:0]  rega,
  input  logic [7:0]  regp,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0] cnt_q,   cnt_d;
  logic [1:0]    digit_q, digit_d;
  logic [15:0]   snap_q,  snap_d;
  logic [1:0]    sel_q,   sel_d;
  logic          armed_q, armed_d;
  logic [3:0]    an_q,    an_d;
  logic [6:0]    seg_q,   seg_d;
  logic          dp_q,    dp_d;

  logic          tick;
  logic          blank;
  logic          show;
  logic [15:0]   src;
  logic [3:0]    nib;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // Next-state scan/snapshot logic; outputs are decoded from next-state values
  always_comb begin
    cnt_d   = cnt_q + CW'(1);
    digit_d = digit_q;
    snap_d  = snap_q;
    sel_d   = sel_q;
    armed_d = armed_q;

    case (ledsel)
      2'd0:    src = addr;
      2'd1:    src = {8'h00, data};
      2'd2:    src = {8'h00, rega};
      default: src = {8'h00, regp};
    endcase

    tick = (cnt_q == CW'(PRESCALE - 1));
    if (tick) begin
      cnt_d   = '0;
      digit_d = digit_q + 2'd1;
      armed_d = 1'b1;
      if (digit_q == 2'd3) begin
        snap_d = src;
        sel_d  = ledsel;
      end
    end

    // armed keeps the display dark until the first frame has been captured
    blank = (32'(cnt_d) < BLANK);
    show  = armed_d && !blank && !((sel_d != 2'd0) && digit_d[1]);
    nib   = snap_d[{digit_d, 2'b00} +: 4];

    an_d  = show ? ~(4'b0001 << digit_d) : 4'hF;
    seg_d = show ? hex7(nib) : 7'h7F;
    dp_d  = !(show && (digit_d == sel_d));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      digit_q <= 2'd3;
      snap_q  <= 16'h0000;
      sel_q   <= 2'd0;
      armed_q <= 1'b0;
      an_q    <= 4'hF;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      snap_q  <= snap_d;
      sel_q   <= sel_d;
      armed_q <= armed_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_led_display.sv
// Directed bench for led_display: expected per-cycle display words are queued
// as each frame's stimulus is set up and popped as the DUT scans them out.
module tb_led_display;

  localparam int unsigned PRESCALE = 4;
  localparam int unsigned BLANK    = 1;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } disp_t;

  localparam disp_t DARK = '{an: 4'hF, seg: 7'h7F, dp: 1'b1};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  ledsel;
  logic [15:0] addr;
  logic [7:0]  data;
  logic [7:0]  rega;
  logic [7:0]  regp;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int tests = 0;
  int fails = 0;

  logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  disp_t sb[$];

  led_display #(.PRESCALE(PRESCALE), .BLANK(BLANK)) dut (
    .clk(clk), .rst(rst), .ledsel(ledsel), .addr(addr), .data(data),
    .rega(rega), .regp(regp), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  function automatic disp_t slot_exp(input logic [15:0] v, input logic [1:0] sel, input int d);
    disp_t      e;
    logic [3:0] nib;
    e = DARK;
    if (sel != 2'd0 && d >= 2) return e;
    nib      = v[4*d +: 4];
    e.an     = 4'hF;
    e.an[d]  = 1'b0;
    e.seg    = hex_tbl[nib];
    e.dp     = (d == int'(sel)) ? 1'b0 : 1'b1;
    return e;
  endfunction

  task automatic check(input string tag, input disp_t exp_v);
    disp_t obs;
    obs = '{an: an, seg: seg, dp: dp};
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $display("FAIL %s: observed an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
               tag, obs.an, obs.seg, obs.dp, exp_v.an, exp_v.seg, exp_v.dp);
      $error("check %s", tag);
    end
  endtask

  task automatic push_dark(input int n);
    repeat (n) sb.push_back(DARK);
  endtask

  task automatic push_frame(input logic [15:0] v, input logic [1:0] sel);
    for (int d = 0; d < 4; d++)
      for (int k = 0; k < int'(PRESCALE); k++)
        sb.push_back((k < int'(BLANK)) ? DARK : slot_exp(v, sel, d));
  endtask

  task automatic consume(input string tag, input int n);
    disp_t e;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL %s: scoreboard empty, observed an=%h seg=%h dp=%b", tag, an, seg, dp);
      end else begin
        e = sb.pop_front();
        check(tag, e);
      end
    end
  endtask

  initial begin
    ledsel = 2'd0;
    addr   = 16'h1A2F;
    data   = 8'h00;
    rega   = 8'h00;
    regp   = 8'h00;

    // Held reset, then release: dark until the first frame has started
    repeat (3) @(posedge clk);
    #1 check("reset_hold", DARK);
    @(negedge clk);
    rst = 1'b0;
    #1 check("post_release", DARK);
    push_dark(3);
    push_frame(16'h1A2F, 2'd0);
    consume("frame_addr", 19);

    // 8-bit source: upper digits blanked, dp on digit 1
    ledsel = 2'd1;
    data   = 8'h85;
    push_frame(16'h0085, 2'd1);
    consume("frame_data", 16);

    // Source change in the middle of digit 1 must not show until next frame
    ledsel = 2'd0;
    addr   = 16'h1A2F;
    push_frame(16'h1A2F, 2'd0);
    consume("midframe_old", 6);
    ledsel = 2'd2;
    rega   = 8'h3C;
    addr   = 16'hFFFF;
    consume("midframe_hold", 10);
    push_frame(16'h003C, 2'd2);
    consume("frame_rega", 16);

    // Status register: dp would sit on blanked digit 3, so it stays high
    ledsel = 2'd3;
    regp   = 8'hFF;
    push_frame(16'h00FF, 2'd3);
    consume("frame_regp", 16);

    // Asynchronous reset in the middle of a shown slot
    push_frame(16'h00FF, 2'd3);
    consume("pre_reset", 6);
    rst = 1'b1;
    #1 check("reset_async", DARK);
    sb.delete();
    ledsel = 2'd0;
    addr   = 16'h1A2F;
    @(negedge clk);
    check("reset_async_hold", DARK);
    rst = 1'b0;
    #1 check("post_release2", DARK);
    push_dark(3);
    push_frame(16'h1A2F, 2'd0);
    consume("frame_after_reset", 19);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
